// File: rtl/dual_rail_capture.sv
// Elastic STAGES-deep pipeline that encodes WIDTH-bit words into {a,~a} dual-rail form.
// Optional history of delivered words is built when DUAL_RAIL_HIST_EN is defined.
module dual_rail_capture #(
  parameter  int WIDTH  = 1,
  parameter  int STAGES = 1,
  parameter  int DEPTH  = 10,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  input  logic [AW-1:0]        hist_rd_idx,
  output logic [2*WIDTH-1:0]   hist_rd_data,
  output logic [CW-1:0]        hist_count,
  output logic                 hist_wrapped
);

  function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] a);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = a[i];
      r[2*i]   = !a[i];
    end
    return r;
  endfunction

  logic [STAGES-1:0]   vld_q, vld_d;
  logic [2*WIDTH-1:0]  data_q [STAGES];
  logic [2*WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0]   load;

  // A stage may load when it or any stage downstream of it has a hole, or the consumer drains.
  always_comb begin
    logic hole;
    hole = out_ready;
    load = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole    = hole || !vld_q[i];
      load[i] = hole;
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < STAGES; i++) data_d[i] = data_q[i];
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) data_d[0] = encode(in_data);
    end
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

`ifdef DUAL_RAIL_HIST_EN
  logic [2*WIDTH-1:0] hist_mem [DEPTH];
  logic [AW-1:0]      wp_q, wp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               wr;
  logic [AW:0]        oldest, sum, rd_ptr;

  assign wr = out_valid && out_ready;

  always_comb begin
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (wr) begin
      wp_d = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (cnt_q == CW'(DEPTH)) wrap_d = 1'b1;
      else                     cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Storage is never cleared; hist_count alone decides which entries are readable.
  always_ff @(posedge clk) begin
    if (wr && !rst) hist_mem[wp_q] <= out_data;
  end

  always_comb begin
    oldest = (cnt_q == CW'(DEPTH)) ? {1'b0, wp_q} : '0;
    sum    = oldest + {1'b0, hist_rd_idx};
    rd_ptr = (sum >= (AW+1)'(DEPTH)) ? sum - (AW+1)'(DEPTH) : sum;
    hist_rd_data = '0;
    if (CW'(hist_rd_idx) < cnt_q) hist_rd_data = hist_mem[rd_ptr[AW-1:0]];
  end

  assign hist_count   = cnt_q;
  assign hist_wrapped = wrap_q;
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_rd_idx;
  assign hist_rd_data    = '0;
  assign hist_count      = '0;
  assign hist_wrapped    = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_capture.sv
// Bench for dual_rail_capture: directed tables plus randomized traffic against a queue-based model.
module tb_dual_rail_capture;

  logic       clk = 1'b0;
  logic       rst;
  // u0: WIDTH=4, STAGES=3, DEPTH=10
  logic       in_valid, in_ready, out_valid, out_ready, hist_wrapped;
  logic [3:0] in_data, hist_rd_idx, hist_count;
  logic [7:0] out_data, hist_rd_data;
  // u1: WIDTH=1, STAGES=1, DEPTH=10
  logic       in_valid1, in_ready1, out_valid1, out_ready1, hist_wrapped1;
  logic [0:0] in_data1;
  logic [3:0] hist_rd_idx1, hist_count1;
  logic [1:0] out_data1, hist_rd_data1;

  always #5 clk = ~clk;

  dual_rail_capture #(.WIDTH(4), .STAGES(3), .DEPTH(10)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data),
    .hist_count(hist_count), .hist_wrapped(hist_wrapped));

  dual_rail_capture #(.WIDTH(1), .STAGES(1), .DEPTH(10)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .hist_rd_idx(hist_rd_idx1), .hist_rd_data(hist_rd_data1),
    .hist_count(hist_count1), .hist_wrapped(hist_wrapped1));

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int nacc   = 0;
  int ndel   = 0;

  typedef struct { logic [7:0] w; int t; } flight_t;
  typedef struct { logic [3:0] din; logic [7:0] exp; } vec_t;

  flight_t    fq[$];   // words accepted but not yet delivered, oldest first
  logic [7:0] hq[$];   // last DEPTH delivered words, oldest first

  function automatic logic [7:0] enc4(input logic [3:0] a);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = a[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One u0 cycle: inputs already set after a negedge; check, clock, update model.
  task automatic step();
    logic acc, dlv;
    logic [7:0] hexp;
    flight_t f;
    #1;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(fq.size() < 3 || out_ready));
      chk("out_valid", 32'(out_valid), 32'(fq.size() > 0 && edges >= fq[0].t + 2));
      if (out_valid && fq.size() > 0) chk("out_data", 32'(out_data), 32'(fq[0].w));
    end
`ifdef DUAL_RAIL_HIST_EN
    hexp = (int'(hist_rd_idx) < hq.size()) ? hq[int'(hist_rd_idx)] : 8'h00;
    chk("hist_count", 32'(hist_count), 32'(hq.size()));
    chk("hist_wrapped", 32'(hist_wrapped), 32'(ndel > 10));
    chk("hist_rd_data", 32'(hist_rd_data), 32'(hexp));
`else
    hexp = 8'h00;
    chk("hist_count", 32'(hist_count), 32'(0));
    chk("hist_wrapped", 32'(hist_wrapped), 32'(0));
    chk("hist_rd_data", 32'(hist_rd_data), 32'(hexp));
`endif
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    @(posedge clk);
    edges++;
    if (rst) begin
      fq.delete();
      hq.delete();
      ndel = 0;
    end else begin
      if (dlv && fq.size() > 0) begin
        f = fq.pop_front();
        hq.push_back(f.w);
        ndel++;
        if (hq.size() > 10) void'(hq.pop_front());
      end
      if (acc) begin
        f.w = enc4(in_data);
        f.t = edges;
        fq.push_back(f);
        nacc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t1[10];
    vec_t t2[6];
    int a0, d0;

    for (int i = 0; i < 10; i++) begin
      t1[i].din = 4'(i & 1);
      t1[i].exp = (i & 1) ? 8'h02 : 8'h01;
    end
    t2[0] = '{4'h0, 8'h55};
    t2[1] = '{4'hF, 8'hAA};
    t2[2] = '{4'hA, 8'h99};
    t2[3] = '{4'h5, 8'h66};
    t2[4] = '{4'h3, 8'h5A};
    t2[5] = '{4'hC, 8'hA5};

    rst = 1'b1;
    in_valid = 0; in_data = 0; out_ready = 1; hist_rd_idx = 0;
    in_valid1 = 0; in_data1 = 0; out_ready1 = 1; hist_rd_idx1 = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_hist_count", 32'(hist_count), 32'(0));
    chk("rst_hist_wrapped", 32'(hist_wrapped), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid1", 32'(out_valid1), 32'(0));
    chk("rst_out_data1", 32'(out_data1), 32'(0));
    @(negedge clk);

    // WIDTH=1, STAGES=1: each word visible one cycle after acceptance
    for (int i = 0; i < 10; i++) begin
      in_valid1 = 1'b1;
      in_data1  = t1[i].din[0];
      #1;
      chk("t1_in_ready", 32'(in_ready1), 32'(1));
      if (i == 0) chk("t1_first_latency", 32'(out_valid1), 32'(0));
      @(posedge clk); @(negedge clk); #1;
      chk("t1_out_valid", 32'(out_valid1), 32'(1));
      chk("t1_out_data", 32'(out_data1), 32'(t1[i].exp[1:0]));
    end
    in_valid1 = 1'b0;
    @(negedge clk);

    // STAGES=3 back-to-back: word i visible right after edge i+2
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6);
      if (i < 6) in_data = t2[i].din;
      else       in_data = 4'h0;
      step();
      if (i >= 2) begin
        chk("t2_out_valid", 32'(out_valid), 32'(1));
        chk("t2_out_data", 32'(out_data), 32'(t2[i-2].exp));
      end
    end
    in_valid = 1'b0;
    step(); step();

    // Stall with out_ready low: exactly STAGES words taken, output held
    out_ready = 1'b0; in_valid = 1'b1; a0 = nacc;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i + 1);
      step();
    end
    #1;
    chk("t3_accepted", 32'(nacc - a0), 32'(3));
    chk("t3_in_ready", 32'(in_ready), 32'(0));
    chk("t3_held_data", 32'(out_data), 32'(enc4(4'h1)));
    d0 = ndel; out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t3_delivered", 32'(ndel - d0), 32'(3));

    // Twelve words through a ten-entry history
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    hist_rd_idx = 4'd0; #1;
`ifdef DUAL_RAIL_HIST_EN
    chk("t4_count", 32'(hist_count), 32'(10));
    chk("t4_wrapped", 32'(hist_wrapped), 32'(1));
    chk("t4_idx0", 32'(hist_rd_data), 32'(8'h59));
    hist_rd_idx = 4'd9; #1;
    chk("t4_idx9", 32'(hist_rd_data), 32'(8'h9A));
`else
    chk("t4_count", 32'(hist_count), 32'(0));
    chk("t4_rd", 32'(hist_rd_data), 32'(0));
`endif
    step();

    // Three words: partial history, out-of-range index reads zero
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    hist_rd_idx = 4'd5; #1;
`ifdef DUAL_RAIL_HIST_EN
    chk("t5_count", 32'(hist_count), 32'(3));
    chk("t5_wrapped", 32'(hist_wrapped), 32'(0));
    chk("t5_idx5", 32'(hist_rd_data), 32'(0));
    hist_rd_idx = 4'd2; #1;
    chk("t5_idx2", 32'(hist_rd_data), 32'(8'h59));
`else
    chk("t5_count", 32'(hist_count), 32'(0));
    chk("t5_idx5", 32'(hist_rd_data), 32'(0));
`endif
    step();

    // Reset with two words in flight: nothing stale comes out afterwards
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 4'h7; step();
    in_data = 4'h8; step();
    do_reset();
    out_ready = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'(0));
    chk("t6_hist_count", 32'(hist_count), 32'(0));
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic, backpressure, history reads and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(149) == 0);
      in_valid    = $urandom_range(1) == 1;
      out_ready   = $urandom_range(3) != 0;
      in_data     = 4'($urandom);
      hist_rd_idx = 4'($urandom_range(15));
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
